stopwatch_bcd_counter: RTL

//  Downstream consumer of the 10 ms timebase generator's square-wave output.

---
 rtl/stopwatch_bcd_counter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_bcd_counter: BCD stopwatch (SS.hh) with run/pause/clear and lap   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module stopwatch_bcd_counter #(
  parameter int EDGE_MODE    = 1,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       resetSW,
  input  logic       tickIn,
  input  logic       startStop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic [3:0] tenths,
  output logic [3:0] hundredths,
  output logic       running,
  output logic       lapActive,
  output logic       wrapPulse
);

  localparam logic [3:0] c_TENS_MAX = (SEC_TENS_MAX > 9) ? 4'd9 : 4'(SEC_TENS_MAX);
  localparam logic [3:0] c_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_running;
  logic       r_tick_prev;
  logic       r_lap_active;
  logic       r_wrap;
  logic [3:0] r_cnt_st, r_cnt_so, r_cnt_te, r_cnt_hu;
  logic [3:0] r_lap_st, r_lap_so, r_lap_te, r_lap_hu;

  logic       w_qual_edge;
  logic       w_inc;
  logic       w_clear_cnt;
  logic       w_lap_next;
  logic       w_lap_capture;
  logic       w_c_hu, w_c_te, w_c_so, w_wrap;
  logic [3:0] w_nxt_st, w_nxt_so, w_nxt_te, w_nxt_hu;

  assign w_qual_edge = (EDGE_MODE != 0) ? (tickIn ^ r_tick_prev) : (tickIn & ~r_tick_prev);
  assign w_inc       = (r_state == S_RUN) && w_qual_edge;

  always_ff @(posedge clk) begin
    if (!resetSW) begin
      r_state     <= S_IDLE;
      r_running   <= 1'b0;
      r_tick_prev <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_running   <= (w_state_next == S_RUN);
      r_tick_prev <= tickIn;
    end
  end

  // startStop takes priority over lap in RUN; clear takes priority over startStop in PAUSE
  always_comb begin
    w_state_next  = r_state;
    w_clear_cnt   = 1'b0;
    w_lap_next    = r_lap_active;
    w_lap_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (startStop) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (startStop) begin
          w_state_next = S_PAUSE;
          w_lap_next   = 1'b0;
        end else if (lap) begin
          if (r_lap_active) begin
            w_lap_next = 1'b0;
          end else begin
            w_lap_next    = 1'b1;
            w_lap_capture = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (clear) begin
          w_state_next = S_IDLE;
          w_clear_cnt  = 1'b1;
        end else if (startStop) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_clear_cnt  = 1'b1;
        w_lap_next   = 1'b0;
      end
    endcase
  end

  // >= rather than == so a corrupted digit still rolls back into 0..9
  assign w_c_hu = w_inc  && (r_cnt_hu >= c_DIGIT_MAX);
  assign w_c_te = w_c_hu && (r_cnt_te >= c_DIGIT_MAX);
  assign w_c_so = w_c_te && (r_cnt_so >= c_DIGIT_MAX);
  assign w_wrap = w_c_so && (r_cnt_st >= c_TENS_MAX);

  always_comb begin
    w_nxt_hu = r_cnt_hu;
    w_nxt_te = r_cnt_te;
    w_nxt_so = r_cnt_so;
    w_nxt_st = r_cnt_st;
    if (w_inc)  w_nxt_hu = w_c_hu ? 4'd0 : r_cnt_hu + 4'd1;
    if (w_c_hu) w_nxt_te = w_c_te ? 4'd0 : r_cnt_te + 4'd1;
    if (w_c_te) w_nxt_so = w_c_so ? 4'd0 : r_cnt_so + 4'd1;
    if (w_c_so) w_nxt_st = w_wrap ? 4'd0 : r_cnt_st + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetSW || w_clear_cnt) begin
      r_cnt_st <= 4'd0;
      r_cnt_so <= 4'd0;
      r_cnt_te <= 4'd0;
      r_cnt_hu <= 4'd0;
      r_wrap   <= 1'b0;
    end else begin
      r_cnt_st <= w_nxt_st;
      r_cnt_so <= w_nxt_so;
      r_cnt_te <= w_nxt_te;
      r_cnt_hu <= w_nxt_hu;
      r_wrap   <= w_wrap;
    end
  end

  // Lap captures the pre-increment count; live count keeps running underneath
  always_ff @(posedge clk) begin
    if (!resetSW) begin
      r_lap_active <= 1'b0;
      r_lap_st     <= 4'd0;
      r_lap_so     <= 4'd0;
      r_lap_te     <= 4'd0;
      r_lap_hu     <= 4'd0;
    end else begin
      r_lap_active <= w_lap_next;
      if (w_lap_capture) begin
        r_lap_st <= r_cnt_st;
        r_lap_so <= r_cnt_so;
        r_lap_te <= r_cnt_te;
        r_lap_hu <= r_cnt_hu;
      end
    end
  end

  assign secTens    = r_lap_active ? r_lap_st : r_cnt_st;
  assign secOnes    = r_lap_active ? r_lap_so : r_cnt_so;
  assign tenths     = r_lap_active ? r_lap_te : r_cnt_te;
  assign hundredths = r_lap_active ? r_lap_hu : r_cnt_hu;
  assign running    = r_running;
  assign lapActive  = r_lap_active;
  assign wrapPulse  = r_wrap;

endmodule
`default_nettype wire
